// File: rtl/mul_add_pkg.sv
// Shared definitions for the mul_add_acc datapath: op encoding, the latency
// helper and the wide-to-narrow saturating clamp used by the final stage.
package mul_add_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Upper bound on the internal sum width that sat_clamp can accept.
    localparam int SAT_MAX_W = 256;

    typedef struct packed {
        logic                        ovf;
        logic signed [SAT_MAX_W-1:0] val;
    } sat_res_t;

    function automatic int mul_add_latency(input int mul_stages);
        return mul_stages + 2;
    endfunction

    // Clamp a sign-extended sum to the signed dwidth range and flag overflow.
    function automatic sat_res_t sat_clamp(input logic signed [SAT_MAX_W-1:0] sum,
                                           input int dwidth);
        logic signed [SAT_MAX_W-1:0] one_v;
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        sat_res_t                    res;
        one_v   = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        max_v   = (one_v <<< (dwidth - 1)) - one_v;
        min_v   = -(one_v <<< (dwidth - 1));
        res.ovf = (sum > max_v) || (sum < min_v);
        if (sum > max_v) begin
            res.val = max_v;
        end else if (sum < min_v) begin
            res.val = min_v;
        end else begin
            res.val = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_add_acc_if.sv
// Operand/result handshake bundle between the PE operand muxes, the
// multiply-add unit and the result write path.
interface mul_add_acc_if #(
    parameter int DWIDTH_A = 32,
    parameter int DWIDTH_B = 32,
    parameter int DWIDTH   = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [DWIDTH_A-1:0] a;
    logic signed [DWIDTH_B-1:0] b;
    logic signed [DWIDTH-1:0]   c;
    logic [1:0]                 op;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [DWIDTH-1:0]   p;
    logic                       ovf;

    modport master (
        output in_valid, a, b, c, op, out_ready,
        input  in_ready, out_valid, p, ovf
    );

    modport slave (
        input  in_valid, a, b, c, op, out_ready,
        output in_ready, out_valid, p, ovf
    );
endinterface

// File: rtl/mul_add_mult_pipe.sv
// MUL_STAGES-deep signed multiplier with a sideband bus carried in lockstep,
// all stages gated by a single advance enable.
module mul_add_mult_pipe #(
    parameter int DWIDTH_A   = 32,
    parameter int DWIDTH_B   = 32,
    parameter int SB_W       = 35,
    parameter int MUL_STAGES = 1
) (
    input  logic                                clk,
    input  logic                                Resetn,
    input  logic                                advance,
    input  logic signed [DWIDTH_A-1:0]          a,
    input  logic signed [DWIDTH_B-1:0]          b,
    input  logic [SB_W-1:0]                     sb_in,
    output logic signed [DWIDTH_A+DWIDTH_B-1:0] prod,
    output logic [SB_W-1:0]                     sb_out
);
    localparam int PW = DWIDTH_A + DWIDTH_B;

    logic signed [PW-1:0]   a_ext_s;
    logic signed [PW-1:0]   b_ext_s;
    logic signed [PW-1:0]   prod_s;
    logic signed [PW-1:0]   prod_r [MUL_STAGES];
    logic [SB_W-1:0]        sb_r   [MUL_STAGES];

    // Both operands widened to the full product width so the low PW bits are exact.
    assign a_ext_s = {{DWIDTH_B{a[DWIDTH_A-1]}}, a};
    assign b_ext_s = {{DWIDTH_A{b[DWIDTH_B-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;

    // Product and sideband shift register, frozen while the unit is stalled.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_r[i] <= {PW{1'b0}};
                sb_r[i]   <= {SB_W{1'b0}};
            end
        end else if (advance) begin
            prod_r[0] <= prod_s;
            sb_r[0]   <= sb_in;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_r[i] <= prod_r[i-1];
                sb_r[i]   <= sb_r[i-1];
            end
        end
    end

    assign prod   = prod_r[MUL_STAGES-1];
    assign sb_out = sb_r[MUL_STAGES-1];

endmodule

// File: rtl/mul_add_acc.sv
// Pipelined signed multiply-add/sub/accumulate unit: input register, multiplier
// pipe, final add/saturate stage with accumulator, under a global stall.
module mul_add_acc
    import mul_add_pkg::*;
#(
    parameter int DWIDTH_A   = 32,
    parameter int DWIDTH_B   = 32,
    parameter int DWIDTH     = 32,
    parameter int MUL_STAGES = 1,
    parameter int SAT_EN     = 0
) (
    input logic          clk,
    input logic          Resetn,
    mul_add_acc_if.slave bus
);
    localparam int PW   = DWIDTH_A + DWIDTH_B;
    localparam int W    = ((PW > DWIDTH) ? PW : DWIDTH) + 1;
    localparam int SB_W = 1 + 2 + DWIDTH;

    logic                       advance_s;
    logic                       s0_valid_r;
    logic signed [DWIDTH_A-1:0] s0_a_r;
    logic signed [DWIDTH_B-1:0] s0_b_r;
    logic signed [DWIDTH-1:0]   s0_c_r;
    logic [1:0]                 s0_op_r;

    logic signed [PW-1:0]       prod_s;
    logic [SB_W-1:0]            sb_out_s;
    logic                       mp_valid_s;
    logic [1:0]                 mp_op_s;
    logic signed [DWIDTH-1:0]   mp_c_s;

    logic signed [W-1:0]         prod_w_s;
    logic signed [W-1:0]         c_w_s;
    logic signed [W-1:0]         acc_w_s;
    logic signed [W-1:0]         sum_s;
    logic signed [SAT_MAX_W-1:0] sum_ext_s;
    sat_res_t                    sat_s;
    logic signed [DWIDTH-1:0]    result_s;

    logic signed [DWIDTH-1:0]   p_r;
    logic                       ovf_r;
    logic                       out_valid_r;
    logic signed [DWIDTH-1:0]   acc_r;

    assign advance_s    = bus.out_ready | ~out_valid_r;
    assign bus.in_ready = advance_s;

    // S0 operand capture.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            s0_valid_r <= 1'b0;
            s0_a_r     <= {DWIDTH_A{1'b0}};
            s0_b_r     <= {DWIDTH_B{1'b0}};
            s0_c_r     <= {DWIDTH{1'b0}};
            s0_op_r    <= 2'b00;
        end else if (advance_s) begin
            s0_valid_r <= bus.in_valid & advance_s;
            s0_a_r     <= bus.a;
            s0_b_r     <= bus.b;
            s0_c_r     <= bus.c;
            s0_op_r    <= bus.op;
        end
    end

    mul_add_mult_pipe #(
        .DWIDTH_A   (DWIDTH_A),
        .DWIDTH_B   (DWIDTH_B),
        .SB_W       (SB_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mult_pipe (
        .clk     (clk),
        .Resetn  (Resetn),
        .advance (advance_s),
        .a       (s0_a_r),
        .b       (s0_b_r),
        .sb_in   ({s0_valid_r, s0_op_r, s0_c_r}),
        .prod    (prod_s),
        .sb_out  (sb_out_s)
    );

    assign mp_valid_s = sb_out_s[SB_W-1];
    assign mp_op_s    = sb_out_s[SB_W-2 -: 2];
    assign mp_c_s     = sb_out_s[DWIDTH-1:0];

    assign prod_w_s = {{(W-PW){prod_s[PW-1]}}, prod_s};
    assign c_w_s    = {{(W-DWIDTH){mp_c_s[DWIDTH-1]}}, mp_c_s};
    assign acc_w_s  = {{(W-DWIDTH){acc_r[DWIDTH-1]}}, acc_r};

    // Final-stage operation select at one bit beyond the widest operand.
    always_comb begin
        sum_s = prod_w_s;
        case (mp_op_s)
            OP_ADD:  sum_s = prod_w_s + c_w_s;
            OP_SUB:  sum_s = prod_w_s - c_w_s;
            OP_ACC:  sum_s = prod_w_s + acc_w_s;
            OP_LOAD: sum_s = prod_w_s;
            default: sum_s = prod_w_s;
        endcase
    end

    assign sum_ext_s = {{(SAT_MAX_W-W){sum_s[W-1]}}, sum_s};
    assign sat_s     = sat_clamp(sum_ext_s, DWIDTH);

    // Overflow is reported in both modes; only the delivered value differs.
    always_comb begin
        result_s = sum_s[DWIDTH-1:0];
        if (SAT_EN != 0) begin
            result_s = DWIDTH'(sat_s.val);
        end else begin
            result_s = sum_s[DWIDTH-1:0];
        end
    end

    // Result register and accumulator; bubbles leave p, ovf and acc untouched.
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            p_r         <= {DWIDTH{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            acc_r       <= {DWIDTH{1'b0}};
        end else if (advance_s) begin
            out_valid_r <= mp_valid_s;
            if (mp_valid_s) begin
                p_r   <= result_s;
                ovf_r <= sat_s.ovf;
                if ((mp_op_s == OP_ACC) || (mp_op_s == OP_LOAD)) begin
                    acc_r <= result_s;
                end
            end
        end
    end

    assign bus.p         = p_r;
    assign bus.ovf       = ovf_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mul_add_acc.sv
// Self-checking bench for mul_add_acc: three configurations (wrap, saturate,
// 3-stage multiplier) behind one stimulus front end and a queue scoreboard.
module tb_mul_add_acc;
    import mul_add_pkg::*;

    logic clk = 1'b0;
    logic Resetn;
    always #5 clk = ~clk;

    mul_add_acc_if bus_w ();
    mul_add_acc_if bus_s ();
    mul_add_acc_if bus_3 ();

    mul_add_acc #(.DWIDTH_A(32), .DWIDTH_B(32), .DWIDTH(32), .MUL_STAGES(1), .SAT_EN(0))
        dut_w (.clk(clk), .Resetn(Resetn), .bus(bus_w));
    mul_add_acc #(.DWIDTH_A(32), .DWIDTH_B(32), .DWIDTH(32), .MUL_STAGES(1), .SAT_EN(1))
        dut_s (.clk(clk), .Resetn(Resetn), .bus(bus_s));
    mul_add_acc #(.DWIDTH_A(32), .DWIDTH_B(32), .DWIDTH(32), .MUL_STAGES(3), .SAT_EN(1))
        dut_3 (.clk(clk), .Resetn(Resetn), .bus(bus_3));

    int          sel = 0;
    logic        in_valid_v = 1'b0;
    logic [31:0] a_v = 32'd0;
    logic [31:0] b_v = 32'd0;
    logic [31:0] c_v = 32'd0;
    logic [1:0]  op_v = 2'b00;
    logic        out_ready_v = 1'b1;

    assign bus_w.in_valid = in_valid_v && (sel == 0);
    assign bus_s.in_valid = in_valid_v && (sel == 1);
    assign bus_3.in_valid = in_valid_v && (sel == 2);
    assign bus_w.a = a_v;  assign bus_s.a = a_v;  assign bus_3.a = a_v;
    assign bus_w.b = b_v;  assign bus_s.b = b_v;  assign bus_3.b = b_v;
    assign bus_w.c = c_v;  assign bus_s.c = c_v;  assign bus_3.c = c_v;
    assign bus_w.op = op_v; assign bus_s.op = op_v; assign bus_3.op = op_v;
    assign bus_w.out_ready = out_ready_v;
    assign bus_s.out_ready = out_ready_v;
    assign bus_3.out_ready = out_ready_v;

    logic        sel_in_ready, sel_out_valid, sel_ovf;
    logic [31:0] sel_p;
    always_comb begin
        case (sel)
            1: begin
                sel_in_ready = bus_s.in_ready; sel_out_valid = bus_s.out_valid;
                sel_p = bus_s.p; sel_ovf = bus_s.ovf;
            end
            2: begin
                sel_in_ready = bus_3.in_ready; sel_out_valid = bus_3.out_valid;
                sel_p = bus_3.p; sel_ovf = bus_3.ovf;
            end
            default: begin
                sel_in_ready = bus_w.in_ready; sel_out_valid = bus_w.out_valid;
                sel_p = bus_w.p; sel_ovf = bus_w.ovf;
            end
        endcase
    end

    int          checks = 0;
    int          failures = 0;
    logic [32:0] exp_q [$];
    logic [31:0] obs_q [$];
    logic [31:0] macc [3];

    // Reference: exact 64-bit arithmetic, then wrap or clamp to 32 bits.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] acc, input bit sat);
        longint      prod_l, sum_l;
        logic [63:0] sum_b;
        logic        ovf;
        logic [31:0] p;
        prod_l = longint'($signed(a)) * longint'($signed(b));
        case (op)
            2'b00:   sum_l = prod_l + longint'($signed(c));
            2'b01:   sum_l = prod_l - longint'($signed(c));
            2'b10:   sum_l = prod_l + longint'($signed(acc));
            default: sum_l = prod_l;
        endcase
        ovf   = (sum_l > 64'sd2147483647) || (sum_l < -64'sd2147483648);
        sum_b = sum_l;
        p     = sum_b[31:0];
        if (sat && ovf) p = (sum_l < 64'sd0) ? 32'h80000000 : 32'h7FFFFFFF;
        return {ovf, p};
    endfunction

    logic [32:0] push_e;
    always @(posedge clk) begin
        if (Resetn && in_valid_v && sel_in_ready) begin
            push_e = model(op_v, a_v, b_v, c_v, macc[sel], sel != 0);
            exp_q.push_back(push_e);
            if (op_v[1]) macc[sel] = push_e[31:0];
        end
    end

    logic        hold_prev = 1'b0;
    logic [31:0] hold_p;
    logic        hold_ovf;
    logic [32:0] pop_e;
    always @(negedge clk) begin
        if (!Resetn) begin
            hold_prev = 1'b0;
        end else begin
            checks++;
            if (sel_in_ready !== (out_ready_v | ~sel_out_valid)) begin
                failures++;
                $display("FAIL in_ready_rule: got %b expected %b", sel_in_ready, out_ready_v | ~sel_out_valid);
            end
            if (hold_prev) begin
                checks++;
                if (sel_out_valid !== 1'b1 || sel_p !== hold_p || sel_ovf !== hold_ovf) begin
                    failures++;
                    $display("FAIL held_stable: got v=%b p=%h ovf=%b expected v=1 p=%h ovf=%b",
                             sel_out_valid, sel_p, sel_ovf, hold_p, hold_ovf);
                end
            end
            if (sel_out_valid && out_ready_v) begin
                checks++;
                obs_q.push_back(sel_p);
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got p=%h with no item outstanding", sel_p);
                end else begin
                    pop_e = exp_q.pop_front();
                    if ({sel_ovf, sel_p} !== pop_e) begin
                        failures++;
                        $display("FAIL scoreboard: got ovf=%b p=%h expected ovf=%b p=%h",
                                 sel_ovf, sel_p, pop_e[32], pop_e[31:0]);
                    end
                end
            end
            hold_prev = sel_out_valid && !out_ready_v;
            hold_p    = sel_p;
            hold_ovf  = sel_ovf;
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        bit done_b = 1'b0;
        op_v = op; a_v = a; b_v = b; c_v = c; in_valid_v = 1'b1;
        for (int t = 0; t < 200 && !done_b; t++) begin
            @(negedge clk);
            if (sel_in_ready) done_b = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_v = 1'b0;
        checks++;
        if (!done_b) begin
            failures++;
            $display("FAIL send_timeout: got no in_ready in 200 cycles expected acceptance");
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    // Sends one item and measures edges from acceptance to out_valid.
    task automatic run_single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, output int lat, output logic [31:0] p,
                              output logic ovf, output logic one_cycle);
        send(op, a, b, c);
        lat = 1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (sel_out_valid) break;
            @(posedge clk);
            lat++;
        end
        p = sel_p; ovf = sel_ovf;
        @(posedge clk); #1;
        @(negedge clk);
        one_cycle = !sel_out_valid;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int edges);
        Resetn = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) macc[i] = 32'd0;
        repeat (edges) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 0; out_ready_v = 1'b1;
        in_valid_v = 1'b1; op_v = 2'b00; a_v = 32'd5; b_v = 32'd5; c_v = 32'd5;
        do_reset(2);
        @(negedge clk);
        checks += 6;
        if (bus_w.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", bus_w.out_valid); end
        if (bus_w.p !== 32'd0)        begin failures++; $display("FAIL rst_p: got %h expected 0", bus_w.p); end
        if (bus_w.ovf !== 1'b0)       begin failures++; $display("FAIL rst_ovf: got %b expected 0", bus_w.ovf); end
        if (bus_w.in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready: got %b expected 1", bus_w.in_ready); end
        if (bus_s.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid_sat: got %b expected 0", bus_s.out_valid); end
        if (bus_3.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid_ms3: got %b expected 0", bus_3.out_valid); end
        @(posedge clk); #1;
        Resetn = 1'b1; in_valid_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus_w.out_valid !== 1'b0) begin failures++; $display("FAIL rst_discard: got out_valid=%b expected 0", bus_w.out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add_sub();
        int lat; logic [31:0] p; logic ovf; logic one;
        sel = 0;
        run_single(OP_ADD, 32'd3, -32'sd4, 32'd10, lat, p, ovf, one);
        checks += 4;
        if (lat !== 3)           begin failures++; $display("FAIL add_latency: got %0d expected 3", lat); end
        if (p !== 32'hFFFFFFFE)  begin failures++; $display("FAIL add_p: got %h expected fffffffe", p); end
        if (ovf !== 1'b0)        begin failures++; $display("FAIL add_ovf: got %b expected 0", ovf); end
        if (one !== 1'b1)        begin failures++; $display("FAIL add_one_cycle: got %b expected 1", one); end
        run_single(OP_SUB, 32'd3, -32'sd4, 32'd10, lat, p, ovf, one);
        checks += 2;
        if (p !== 32'hFFFFFFEA)  begin failures++; $display("FAIL sub_p: got %h expected ffffffea", p); end
        if (ovf !== 1'b0)        begin failures++; $display("FAIL sub_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_acc_chain();
        logic [31:0] exp_a [5];
        exp_a[0] = 32'd10; exp_a[1] = 32'd11; exp_a[2] = 32'd5; exp_a[3] = 32'd101; exp_a[4] = 32'd5;
        sel = 0; obs_q.delete();
        send(OP_LOAD, 32'd2, 32'd5, 32'd0);
        send(OP_ACC, 32'd1, 32'd1, 32'd0);
        send(OP_ACC, -32'sd3, 32'd2, 32'd0);
        send(OP_ADD, 32'd1, 32'd1, 32'd100);
        send(OP_ACC, 32'd0, 32'd0, 32'd0);
        drain();
        checks++;
        if (obs_q.size() != 5) begin
            failures++; $display("FAIL acc_count: got %0d expected 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== exp_a[i]) begin
                    failures++; $display("FAIL acc_chain[%0d]: got %h expected %h", i, obs_q[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] p; logic ovf; logic one;
        sel = 0;
        run_single(OP_ADD, 32'h7FFFFFFF, 32'd2, 32'd0, lat, p, ovf, one);
        checks += 2;
        if (p !== 32'hFFFFFFFE) begin failures++; $display("FAIL wrap_p: got %h expected fffffffe", p); end
        if (ovf !== 1'b1)       begin failures++; $display("FAIL wrap_ovf: got %b expected 1", ovf); end
        sel = 1;
        run_single(OP_ADD, 32'h7FFFFFFF, 32'd2, 32'd0, lat, p, ovf, one);
        checks += 2;
        if (p !== 32'h7FFFFFFF) begin failures++; $display("FAIL sat_pos_p: got %h expected 7fffffff", p); end
        if (ovf !== 1'b1)       begin failures++; $display("FAIL sat_pos_ovf: got %b expected 1", ovf); end
        run_single(OP_SUB, 32'h80000000, 32'd1, 32'd1, lat, p, ovf, one);
        checks += 2;
        if (p !== 32'h80000000) begin failures++; $display("FAIL sat_neg_p: got %h expected 80000000", p); end
        if (ovf !== 1'b1)       begin failures++; $display("FAIL sat_neg_ovf: got %b expected 1", ovf); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        sel = 0; obs_q.delete(); out_ready_v = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(OP_ADD, 32'(i + 1), 32'(i + 2), 32'(100 * i));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready_v = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (k == 0) held = sel_p;
                    checks += 3;
                    if (sel_out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", sel_out_valid); end
                    if (sel_in_ready !== 1'b0)  begin failures++; $display("FAIL bp_in_ready: got %b expected 0", sel_in_ready); end
                    if (sel_p !== held)         begin failures++; $display("FAIL bp_p_stable: got %h expected %h", sel_p, held); end
                    @(posedge clk); #1;
                end
                out_ready_v = 1'b1;
            end
        join
        drain();
        checks++;
        if (obs_q.size() != 8) begin
            failures++; $display("FAIL bp_count: got %0d expected 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[i] !== 32'((i + 1) * (i + 2) + 100 * i)) begin
                    failures++; $display("FAIL bp_order[%0d]: got %h expected %h", i, obs_q[i], 32'((i + 1) * (i + 2) + 100 * i));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        sel = 0; out_ready_v = 1'b1;
        send(OP_LOAD, 32'd7, 32'd1, 32'd0);
        drain();
        out_ready_v = 1'b0;
        for (int i = 0; i < 3; i++) send(OP_ACC, 32'd1, 32'd1, 32'd0);
        do_reset(2);
        out_ready_v = 1'b1;
        Resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (sel_out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_flush: got out_valid=%b expected 0", sel_out_valid); end
            @(posedge clk); #1;
        end
        obs_q.delete();
        send(OP_ACC, 32'd1, 32'd1, 32'd0);
        drain();
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'd1) begin
            failures++; $display("FAIL mid_rst_acc: got count=%0d p=%h expected count=1 p=1",
                                 obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 32'hX);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] p; logic ovf; logic one;
        bit done_r = 1'b0;
        sel = 2; out_ready_v = 1'b1;
        run_single(OP_ADD, 32'd3, -32'sd4, 32'd10, lat, p, ovf, one);
        checks += 2;
        if (lat !== mul_add_latency(3)) begin failures++; $display("FAIL ms3_latency: got %0d expected 5", lat); end
        if (p !== 32'hFFFFFFFE)         begin failures++; $display("FAIL ms3_p: got %h expected fffffffe", p); end
        obs_q.delete();
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [31:0] ra, rb, rc;
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    ra = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(int'($urandom_range(0, 200)) - 100);
                    rb = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(int'($urandom_range(0, 200)) - 100);
                    rc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(int'($urandom_range(0, 200)) - 100);
                    send(2'($urandom_range(0, 3)), ra, rb, rc);
                end
                done_r = 1'b1;
            end
            begin
                while (!done_r) begin
                    @(posedge clk); #1;
                    out_ready_v = ($urandom_range(0, 3) != 0);
                end
                out_ready_v = 1'b1;
            end
        join
        drain();
        checks++;
        if (obs_q.size() != 10000) begin
            failures++; $display("FAIL rand_count: got %0d expected 10000", obs_q.size());
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_acc_chain();
        test_overflow();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
